// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Shared types and helpers for the serializer transmit stage.
//   ser_state_t : controller states (idle, shifting data, sending parity)
//   cnt_w(n)    : width of a down-counter that must hold n-1
// ----------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// ----------------------------------------------------------------------------
// ser_bit_counter
// Loadable down-counter that counts the data bits still to be sent.
// It stops at zero and never wraps.
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   load_i       : load load_val_i (has priority over en_i)
//   load_val_i   : value to load
//   en_i         : decrement by one (ignored when already zero)
//   count_o      : current count
//   is_zero_o    : count_o == 0
// ----------------------------------------------------------------------------
module ser_bit_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         is_zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count_o   = count_q;
    assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/serializer_ctrl.sv
// ----------------------------------------------------------------------------
// serializer_ctrl
// Parallel-to-serial transmit stage. Accepts a NUM_BITS word over a
// valid/ready handshake, shifts it out one bit per bit_en tick and marks the
// first data bit (frame_start) and the edge retiring the last bit (frame_end).
// Optional feature macro: PARITY_EN -- when defined, an even-parity bit
// (XOR of the accepted word) follows the last data bit.
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   in_valid     : upstream word valid
//   in_data      : word to send, sampled only on the accept edge
//   in_ready     : word can be accepted this cycle
//   bit_en       : bit-rate tick; the current bit advances only when high
//   ser_out      : serial data, 0 when not transmitting
//   ser_valid    : ser_out carries a frame bit (data or parity)
//   frame_start  : first data bit of a frame is on ser_out
//   frame_end    : high on the cycle whose edge retires the last frame bit
//   busy         : controller is not idle
// ----------------------------------------------------------------------------
module serializer_ctrl
    import ser_pkg::*;
#(
    parameter int NUM_BITS  = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                in_ready,
    input  logic                bit_en,
    output logic                ser_out,
    output logic                ser_valid,
    output logic                frame_start,
    output logic                frame_end,
    output logic                busy
);

    localparam int CNT_W = cnt_w(NUM_BITS);
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(NUM_BITS - 1);

    ser_state_t          state_q, state_d;
    logic [NUM_BITS-1:0] shift_q;
    logic [NUM_BITS-1:0] shift_adv;
    logic                cur_bit;
    logic [CNT_W-1:0]    count;
    logic                cnt_zero;
    logic                last_bit;
    logic                retire;
    logic                accept;
    logic                parity_bit;

    // Direction of transmission only changes which end of the shift
    // register is presented and which way it moves.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign cur_bit   = shift_q[NUM_BITS-1];
            assign shift_adv = {shift_q[NUM_BITS-2:0], 1'b0};
        end else begin : g_lsb_first
            assign cur_bit   = shift_q[0];
            assign shift_adv = {1'b0, shift_q[NUM_BITS-1:1]};
        end
    endgenerate

`ifdef PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^in_data;
        end
    end

    assign parity_bit = parity_q;
    assign last_bit   = (state_q == S_PARITY);
`else
    assign parity_bit = 1'b0;
    assign last_bit   = (state_q == S_SHIFT) && cnt_zero;
`endif

    // Retiring the last bit frees the stage in the same cycle, so a waiting
    // word can be taken with no idle gap. Ready is held low while in reset.
    assign retire   = last_bit && bit_en;
    assign in_ready = !reset && ((state_q == S_IDLE) || retire);
    assign accept   = in_valid && in_ready;

    ser_bit_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (FIRST_CNT),
        .en_i       ((state_q == S_SHIFT) && bit_en),
        .count_o    (count),
        .is_zero_o  (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else if (accept) begin
            shift_q <= in_data;
        end else if ((state_q == S_SHIFT) && bit_en) begin
            shift_q <= shift_adv;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_en && cnt_zero) begin
`ifdef PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = accept ? S_SHIFT : S_IDLE;
`endif
                end
            end
            S_PARITY: begin
                if (bit_en) state_d = accept ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ser_valid   = 1'b0;
        ser_out     = 1'b0;
        frame_start = 1'b0;
        frame_end   = retire;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_SHIFT: begin
                ser_valid   = 1'b1;
                ser_out     = cur_bit;
                frame_start = (count == FIRST_CNT);
            end
            S_PARITY: begin
                ser_valid = 1'b1;
                ser_out   = parity_bit;
            end
            default: ;
        endcase
    end

endmodule
